// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: valid/ready request side, valid/ready result side.
// The master drives operands and out_ready; the slave (ALU) drives in_ready, out_valid, result, zero.
interface alu_multicycle_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_op, in_a, in_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: logic/add/sub finish one cycle after accept; mul/div take XLEN/ITER_BITS more.
// One op in flight; in_ready only in IDLE, and the result holds in DONE until out_ready.
module alu_multicycle #(
  parameter int XLEN      = 32,
  parameter int ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_multicycle_if.slave io_alu
);
  localparam int STEPS = XLEN / ITER_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_div;
  logic            r_sel_hi;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_is_iter;
  logic            w_last;
  logic [XLEN-1:0] w_fast_res;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  assign w_accept  = (r_state == IDLE) && io_alu.in_valid;
  assign w_is_iter = (io_alu.alu_op == OP_MUL) || (io_alu.alu_op == OP_MULHU) ||
                     (((io_alu.alu_op == OP_DIVU) || (io_alu.alu_op == OP_REMU)) &&
                      (io_alu.in_b != '0));
  assign w_last    = (r_cnt == CW'(STEPS - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_is_iter ? BUSY : DONE;
      BUSY:    if (w_last) w_state_nxt = DONE;
      DONE:    if (io_alu.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // DIVU/REMU entries only matter for the divide-by-zero path.
  always_comb begin
    w_fast_res = '0;
    case (io_alu.alu_op)
      OP_AND:  w_fast_res = io_alu.in_a & io_alu.in_b;
      OP_OR:   w_fast_res = io_alu.in_a | io_alu.in_b;
      OP_ADD:  w_fast_res = io_alu.in_a + io_alu.in_b;
      OP_SUB:  w_fast_res = io_alu.in_a - io_alu.in_b;
      OP_DIVU: w_fast_res = '1;
      OP_REMU: w_fast_res = io_alu.in_a;
      default: w_fast_res = '0;
    endcase
  end

  // hi:lo is the product (shift-add, multiplier in lo) or remainder:quotient (restoring divide).
  always_comb begin
    logic [XLEN:0]   v_ext;
    logic [XLEN-1:0] v_hi;
    logic [XLEN-1:0] v_lo;
    v_ext = '0;
    v_hi  = r_hi;
    v_lo  = r_lo;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (r_div) begin
        v_ext = {v_hi, v_lo[XLEN-1]};
        v_lo  = {v_lo[XLEN-2:0], 1'b0};
        if (v_ext >= {1'b0, r_b}) begin
          v_ext   = v_ext - {1'b0, r_b};
          v_lo[0] = 1'b1;
        end
        v_hi = v_ext[XLEN-1:0];
      end else begin
        v_ext = {1'b0, v_hi} + (v_lo[0] ? {1'b0, r_a} : '0);
        v_lo  = {v_ext[0], v_lo[XLEN-1:1]};
        v_hi  = v_ext[XLEN:1];
      end
    end
    w_hi_nxt = v_hi;
    w_lo_nxt = v_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_div    <= 1'b0;
      r_sel_hi <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div    <= io_alu.alu_op[2];
            r_sel_hi <= io_alu.alu_op[0];
            r_a      <= io_alu.in_a;
            r_b      <= io_alu.in_b;
            r_hi     <= '0;
            r_lo     <= io_alu.alu_op[2] ? io_alu.in_a : io_alu.in_b;
            r_cnt    <= '0;
            if (!w_is_iter) r_result <= w_fast_res;
          end
        end
        BUSY: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= r_sel_hi ? w_hi_nxt : w_lo_nxt;
            r_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_alu.in_ready  = (r_state == IDLE);
  assign io_alu.out_valid = (r_state == DONE);
  assign io_alu.result    = r_result;
  assign io_alu.zero      = (r_result == '0);
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width in bits; legal values 8..64.
REQ-002 Parameter: ITER_BITS, default 1, quotient/product bits resolved per iteration cycle; legal values 1, 2 or 4, dividing XLEN.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 alu_op  input  4  operation select, sampled on accept.
REQ-008 in_a  input  XLEN  operand a, sampled on accept.
REQ-009 in_b  input  XLEN  operand b, sampled on accept.
REQ-010 out_valid  output  1  result/zero valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  XLEN  operation result.
REQ-013 zero  output  1  1 when result == 0, else 0.

Function
REQ-014 Op encodings shall be: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1000 MUL (low XLEN of unsigned a*b); 1001 MULHU (high XLEN); 1100 DIVU (a/b unsigned); 1101 REMU (a%b unsigned); all others illegal.
REQ-015 Accept shall occur on a cycle where in_valid && in_ready; operands and op are registered at accept and later input changes are ignored.
REQ-016 FSM states shall be IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-017 IDLE -> DONE on accept of AND/OR/ADD/SUB, illegal op, or DIVU/REMU with in_b == 0.
REQ-018 IDLE -> BUSY on accept of MUL/MULHU, or DIVU/REMU with in_b != 0.
REQ-019 BUSY shall last exactly XLEN/ITER_BITS cycles (shift-add multiply, restoring divide), then -> DONE.
REQ-020 DONE -> IDLE on the cycle out_ready = 1; while out_ready = 0, result and zero hold stable.
REQ-021 out_valid = 1 only in DONE.
REQ-022 Latency, accept cycle at edge N: single-cycle class reaches out_valid at edge N+1; iterative class at edge N+1+XLEN/ITER_BITS.
REQ-023 ADD/SUB shall wrap modulo 2^XLEN; no carry or overflow output.
REQ-024 Divide by zero: DIVU result = all ones; REMU result = in_a (RISC-V semantics).
REQ-025 Illegal op: result = 0, zero = 1.
REQ-026 zero shall be derived from the registered result.
REQ-027 Back-to-back throughput: no accept in the DONE cycle; the next accept is no earlier than the cycle after DONE exits.
REQ-028 out_ready while not in DONE shall have no effect.

Reset
REQ-029 rst_n = 0 at a rising edge forces IDLE from any state, including mid-BUSY; the in-flight operation is discarded.
REQ-030 Reset values: in_ready = 1, out_valid = 0, result = 0, zero = 1, iteration counter = 0.
REQ-031 A request presented with rst_n = 0 shall not be accepted.

Verification
REQ-032 ADD, XLEN=32: a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid at N+1, result=0, zero=1; SUB a=5, b=7 -> 0xFFFFFFFE, zero=0.
REQ-033 MUL/MULHU, XLEN=32, ITER_BITS=1: a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid at N+33; MUL=0x00000001, MULHU=0xFFFFFFFE.
REQ-034 DIVU/REMU: a=100, b=7 -> 14 and 2 after 33 cycles; b=0 -> DIVU 0xFFFFFFFF, REMU 100 at N+1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result, zero, out_valid stable, in_ready=0; release -> IDLE next edge.
REQ-036 Reset mid-op: assert rst_n=0 at BUSY cycle 10 of a DIVU -> next edge in_ready=1, out_valid=0, result=0; a following ADD 2+3 returns 5 at N+1.
REQ-037 Parameter sweep: XLEN=8, ITER_BITS in {1,2,4}, random ops vs. reference model; iterative latency = 1+8/ITER_BITS.
